line_sweep_ctrl: RTL
====================

# line_sweep_ctrl

Parametrised sequencer for the 2-D lane-permutation datapath. It sweeps every line of the state memory over a configurable number of rounds. For each line it fetches the line, steps through every (row, column) cell with a sub/add ALU pair and a shifted source column, and writes the line back. It replaces the fixed 5x5, single-pass, 3j-shift controller and adds a memory handshake, multi-round operation and optional abort.

## Interface
Parameters:
- ROWS, 5, rows per line (>=1)
- COLS, 5, columns per line (>=2)
- SHIFT, 3, per-row source-column offset; must be < COLS
- LINES, 64, lines in state memory (>=2)
- ROUND_W, 5, width of round count

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a sweep; sampled only in IDLE
- rounds  in  ROUND_W  number of rounds; latched at start; 0 is treated as 1
- mem_ack  in  1  memory accepted the current rd_req/wr_req; may be high in the same cycle as the request
- abort  in  1  synchronous abort (see Configuration)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of a full sweep
- rd_req  out  1  line read request; held until mem_ack
- wr_req  out  1  line write request; held until mem_ack
- ld_line  out  1  datapath latches read data into the line register
- line_addr  out  $clog2(LINES)  current line index
- row_idx  out  $clog2(ROWS)  current row (0 if ROWS=1)
- col_idx  out  $clog2(COLS)  current destination column
- src_col  out  $clog2(COLS)  (col_idx + SHIFT*row_idx) mod COLS
- alu_en  out  1  ALU operation valid this cycle
- alu_op  out  1  0 = sub, 1 = add
- round_idx  out  ROUND_W  current round, from 0

## Operation
- States: IDLE, FETCH, LATCH, SUB, ADD, WRITE, DONE.
- IDLE -> FETCH on start. Latch rounds, with 0 treated as 1. Clear line, row, column and round counters.
- FETCH: rd_req=1. Move to LATCH in the cycle after mem_ack is sampled high.
- LATCH: ld_line=1 for one cycle. Move to SUB with row=0, col=0, src_col=0.
- SUB: alu_en=1, alu_op=0. Move to ADD.
- ADD: alu_en=1, alu_op=1.
  - If col<COLS-1: col+1, src_col+1 mod COLS, return to SUB.
  - Else if row<ROWS-1: row+1, col=0, row_base=(row_base+SHIFT) mod COLS, src_col=new row_base, return to SUB.
  - Else go to WRITE.
- src_col is computed incrementally with compare-and-subtract. There is no multiplier or divider.
- WRITE: wr_req=1. On mem_ack:
  - If line<LINES-1: line+1, go to FETCH.
  - Else if round<rounds-1: round+1, line=0, go to FETCH.
  - Else go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- start while busy is ignored.
- mem_ack outside FETCH/WRITE is ignored.
- line_addr, row_idx, col_idx, src_col and round_idx hold their values between updates. They are valid whenever busy=1.

## Timing
- Reset value of every output and counter is 0; state is IDLE. Reset asserted mid-sweep returns to IDLE immediately and produces no done.
- All outputs are registered or decoded from the state register only. There are no combinational input-to-output paths.
- Cycles per line with zero-wait mem_ack = 1 (FETCH) + 1 (LATCH) + 2*ROWS*COLS + 1 (WRITE) = 53 for the defaults.
- Each extra cycle of mem_ack delay adds one cycle.
- Latency from the start edge to the done pulse = LINES*rounds*cycles_per_line + 1. With the defaults, zero-wait memory and rounds=1 this is 3393 cycles.
- rd_req and wr_req are never high together. rd_req rises the cycle after the start sample or after a WRITE ack.

## Configuration
- SWEEP_CTRL_ABORT_EN:
  - Defined: abort=1 in any busy state returns the FSM to IDLE on the next edge. rd_req, wr_req and alu_en drop at that edge and done is not pulsed. Abort has priority over mem_ack in the same cycle.
  - Undefined: abort is ignored and a sweep always completes. The port remains present.

## Test plan
- Defaults, rounds=1, mem_ack tied high, start pulse -> done after exactly 3393 cycles, and 64 rd_req and 64 wr_req handshakes.
- ROWS=5, COLS=5, SHIFT=3, line 0 -> src_col sequence for row 1 is 3,4,0,1,2 and for row 4 is 2,3,4,0,1; alu_op alternates 0,1 over 50 cycles.
- mem_ack delayed 3 cycles on each request -> rd_req/wr_req held for 4 cycles each; total latency grows by 6 cycles per line; no ALU activity during the waits.
- rounds=0 vs rounds=1 -> identical cycle counts. rounds=3 -> round_idx steps 0,1,2; line_addr wraps 63->0 twice; one done pulse.
- With SWEEP_CTRL_ABORT_EN, abort at line 10 in ADD -> IDLE next cycle, busy=0, no done; a new start restarts at line 0. Without the macro the same stimulus completes normally.
- rst pulsed mid-WRITE and start pulsed while busy -> all outputs 0 right after reset; the start received while busy has no effect on count or latency.

Source files
------------

// File: rtl/line_sweep_ctrl.sv
// line_sweep_ctrl: sweeps every state-memory line over N rounds, fetch -> per-cell sub/add -> write back.
// Latency: 3 + 2*ROWS*COLS cycles per line with zero-wait memory, +1 per mem_ack wait cycle; done one cycle after last write.
// Backpressure: rd_req/wr_req are held until mem_ack; the sweep stalls in FETCH/WRITE while memory is not ready.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, rounds       begin a sweep (sampled in IDLE); round count latched at start, 0 means 1
//   mem_ack             memory accepted the pending rd_req/wr_req (may coincide with the request)
//   abort               synchronous abort, honoured only when SWEEP_CTRL_ABORT_EN is defined
//   busy, done          not-IDLE flag; one-cycle pulse at the end of a full sweep
//   rd_req, wr_req      line read / write request, held until mem_ack
//   ld_line             datapath latches read data into the line register
//   line_addr, row_idx, col_idx, src_col, round_idx   sweep position (valid while busy)
//   alu_en, alu_op      ALU operation valid; 0 = sub, 1 = add
//
// Optional feature macro: SWEEP_CTRL_ABORT_EN (abort support).

module line_sweep_ctrl #(
  parameter int ROWS    = 5,
  parameter int COLS    = 5,
  parameter int SHIFT   = 3,
  parameter int LINES   = 64,
  parameter int ROUND_W = 5,
  localparam int LW     = $clog2(LINES),
  localparam int CW     = $clog2(COLS),
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ROUND_W-1:0] rounds,
  input  logic               mem_ack,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               rd_req,
  output logic               wr_req,
  output logic               ld_line,
  output logic [LW-1:0]      line_addr,
  output logic [RW-1:0]      row_idx,
  output logic [CW-1:0]      col_idx,
  output logic [CW-1:0]      src_col,
  output logic               alu_en,
  output logic               alu_op,
  output logic [ROUND_W-1:0] round_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_SUB, S_ADD, S_WRITE, S_DONE
  } state_t;

  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(LINES - 1);
  localparam logic [CW:0]   SHIFT_W   = (CW+1)'(SHIFT);
  localparam logic [CW:0]   COLS_W    = (CW+1)'(COLS);

  state_t             state, state_nxt;
  logic [ROUND_W-1:0] rounds_q;
  logic [CW-1:0]      row_base;

  logic abort_hit;
`ifdef SWEEP_CTRL_ABORT_EN
  assign abort_hit = abort && (state != S_IDLE);
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_hit    = 1'b0;
`endif

  logic col_last, row_last, line_last, round_last;
  assign col_last   = (col_idx == LAST_COL);
  assign row_last   = (row_idx == LAST_ROW);
  assign line_last  = (line_addr == LAST_LINE);
  assign round_last = (round_idx == (rounds_q - 1'b1));

  // Source column tracked incrementally: row_base = SHIFT*row mod COLS, and
  // both it and src_col advance by compare-and-subtract. Operands are < COLS,
  // so a single conditional subtract is enough.
  logic [CW:0]   rb_sum;
  logic [CW-1:0] rb_next;
  logic [CW-1:0] src_inc;
  assign rb_sum  = {1'b0, row_base} + SHIFT_W;
  assign rb_next = (rb_sum >= COLS_W) ? CW'(rb_sum - COLS_W) : rb_sum[CW-1:0];
  assign src_inc = (src_col == LAST_COL) ? '0 : src_col + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    ld_line   = 1'b0;
    alu_en    = 1'b0;
    alu_op    = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        rd_req = 1'b1;
        if (mem_ack) state_nxt = S_LATCH;
      end
      S_LATCH: begin
        ld_line   = 1'b1;
        state_nxt = S_SUB;
      end
      S_SUB: begin
        alu_en    = 1'b1;
        state_nxt = S_ADD;
      end
      S_ADD: begin
        alu_en    = 1'b1;
        alu_op    = 1'b1;
        state_nxt = (col_last && row_last) ? S_WRITE : S_SUB;
      end
      S_WRITE: begin
        wr_req = 1'b1;
        if (mem_ack) state_nxt = (line_last && round_last) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort_hit) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rounds_q  <= '0;
      line_addr <= '0;
      row_idx   <= '0;
      col_idx   <= '0;
      src_col   <= '0;
      row_base  <= '0;
      round_idx <= '0;
    end else if (!abort_hit) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rounds_q  <= (rounds == '0) ? ROUND_W'(1) : rounds;
            line_addr <= '0;
            row_idx   <= '0;
            col_idx   <= '0;
            src_col   <= '0;
            row_base  <= '0;
            round_idx <= '0;
          end
        end
        S_LATCH: begin
          row_idx  <= '0;
          col_idx  <= '0;
          src_col  <= '0;
          row_base <= '0;
        end
        S_ADD: begin
          if (!col_last) begin
            col_idx <= col_idx + 1'b1;
            src_col <= src_inc;
          end else if (!row_last) begin
            row_idx  <= row_idx + 1'b1;
            col_idx  <= '0;
            row_base <= rb_next;
            src_col  <= rb_next;
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            if (!line_last) begin
              line_addr <= line_addr + 1'b1;
            end else if (!round_last) begin
              round_idx <= round_idx + 1'b1;
              line_addr <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
